// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if
// Register-bus bundle between the core's data path and the external interrupt
// controller.
//   sel_i    : register block selected this cycle
//   rd_i     : read strobe (qualified by sel_i)
//   wr_i     : write strobe (qualified by sel_i)
//   addr_i   : word offset 0 PENDING, 1 ENABLE, 2 TRIGGER, 3 CLAIM/COMPLETE
//   wdata_i  : write data
//   rdata_o  : registered read data returned by the controller
// The _i/_o suffixes are named from the controller's point of view.
// -----------------------------------------------------------------------------
interface irq_controller_if;
   logic        sel_i;
   logic        rd_i;
   logic        wr_i;
   logic [1:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;

   // Bus driver side (core / testbench).
   modport master (
      output sel_i,
      output rd_i,
      output wr_i,
      output addr_i,
      output wdata_i,
      input  rdata_o
   );

   // Register block side (irq_controller).
   modport slave (
      input  sel_i,
      input  rd_i,
      input  wr_i,
      input  addr_i,
      input  wdata_i,
      output rdata_o
   );
endinterface

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// External interrupt controller: arbitrates NUM_SRC peripheral interrupt lines
// into the single machine external interrupt request (meip_o) of the CSR unit.
// Source k reports ID k+1; ID 0 means "no interrupt".
//
// Ports:
//   clk_i      : core clock, all state on the rising edge
//   reset_i    : asynchronous active-low reset
//   irq_src_i  : raw asynchronous peripheral interrupt lines
//   ack_i      : interrupt acknowledge from the CSR unit (hardware claim)
//   bus        : register bus (irq_controller_if.slave)
//                0 PENDING (RO), 1 ENABLE (RW), 2 TRIGGER (RW, 1 = edge),
//                3 CLAIM (read = claim in ASSERT) / COMPLETE (write ID)
//   meip_o     : registered external interrupt request
//
// Flow: IDLE picks the lowest-index eligible source and latches its ID;
// ASSERT raises meip_o and waits for a claim (ack_i or CLAIM read) or a
// withdraw (source no longer eligible); SERVICE waits for the matching ID to
// be written to COMPLETE. Only one interrupt is in flight at a time.
// -----------------------------------------------------------------------------
module irq_controller #(
   parameter int NUM_SRC = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] irq_src_i,
   input  logic               ack_i,
   irq_controller_if.slave    bus,
   output logic               meip_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_PENDING = 2'd0;
   localparam logic [1:0] ADDR_ENABLE  = 2'd1;
   localparam logic [1:0] ADDR_TRIGGER = 2'd2;
   localparam logic [1:0] ADDR_CLAIM   = 2'd3;

   // Lowest set bit wins; returns its ID (index + 1), or 0 when none is set.
   function automatic logic [4:0] f_first_id(input logic [NUM_SRC-1:0] v);
      logic [4:0] id;
      id = 5'd0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         id = v[k] ? 5'(k + 1) : id;
      end
      return id;
   endfunction

   // ---------------------------------------------------------------- state
   logic [NUM_SRC-1:0] r_sync1;
   logic [NUM_SRC-1:0] r_sync2;
   logic [NUM_SRC-1:0] r_sync3;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_trigger;
   logic [NUM_SRC-1:0] r_in_service;
   state_t             r_state;
   logic [4:0]         r_cur_id;
   logic               r_meip;
   logic [31:0]        r_rdata;

   // ---------------------------------------------------------------- wires
   logic               w_rd;
   logic               w_wr;
   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_cur_onehot;
   logic               w_cur_eligible;
   logic               w_any_eligible;
   logic [4:0]         w_win_id;
   logic               w_claim;
   logic               w_complete;
   logic [NUM_SRC-1:0] w_claim_mask;
   logic [NUM_SRC-1:0] w_complete_mask;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [NUM_SRC-1:0] w_in_service_nxt;
   logic [31:0]        w_rd_data;
   logic               w_unused_wdata;

   // A simultaneous read and write is treated as a write only.
   assign w_rd = bus.sel_i & bus.rd_i & ~bus.wr_i;
   assign w_wr = bus.sel_i & bus.wr_i;

   assign w_edge         = r_sync2 & ~r_sync3;
   assign w_eligible     = r_pending & r_enable & ~r_in_service;
   assign w_any_eligible = |w_eligible;
   assign w_win_id       = f_first_id(w_eligible);
   assign w_cur_eligible = |(w_eligible & w_cur_onehot);

   // ack_i and a CLAIM read in the same cycle collapse into one claim.
   assign w_claim    = (r_state == ST_ASSERT) &
                       (ack_i | (w_rd & (bus.addr_i == ADDR_CLAIM)));
   assign w_complete = (r_state == ST_SERVICE) & w_wr &
                       (bus.addr_i == ADDR_CLAIM) &
                       (bus.wdata_i[4:0] == r_cur_id);

   assign w_claim_mask    = {NUM_SRC{w_claim}} & w_cur_onehot;
   assign w_complete_mask = {NUM_SRC{w_complete}} & w_cur_onehot;

   // Only the low ID bits and the low NUM_SRC bits of wdata_i are meaningful.
   assign w_unused_wdata = ^bus.wdata_i;

   assign meip_o      = r_meip;
   assign bus.rdata_o = r_rdata;

   // Decode the latched ID into a per-source mask (ID 0 selects nothing).
   always_comb begin
      w_cur_onehot = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_cur_onehot[k] = (r_cur_id == 5'(k + 1));
      end
   end

   // Next pending / in-service values; an edge in the claim cycle re-arms the
   // bit (set wins), level sources simply mirror the synchronized line.
   always_comb begin
      w_pending_nxt    = (r_trigger & ((r_pending & ~w_claim_mask) | w_edge)) |
                         (~r_trigger & r_sync2);
      w_in_service_nxt = (r_in_service | w_claim_mask) & ~w_complete_mask;
   end

   // Read multiplexer; CLAIM returns 0 while no interrupt is in flight.
   always_comb begin
      w_rd_data = 32'd0;
      case (bus.addr_i)
         ADDR_PENDING: w_rd_data = 32'(r_pending);
         ADDR_ENABLE:  w_rd_data = 32'(r_enable);
         ADDR_TRIGGER: w_rd_data = 32'(r_trigger);
         ADDR_CLAIM: begin
            if (r_state == ST_IDLE) begin
               w_rd_data = 32'd0;
            end else begin
               w_rd_data = {27'd0, r_cur_id};
            end
         end
         default: w_rd_data = 32'd0;
      endcase
   end

   // Two-flop synchronizer plus one history flop for rising-edge detection.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= irq_src_i;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // Pending and in-service bookkeeping.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_pending    <= '0;
         r_in_service <= '0;
      end else begin
         r_pending    <= w_pending_nxt;
         r_in_service <= w_in_service_nxt;
      end
   end

   // ENABLE and TRIGGER register writes; PENDING writes are dropped.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_enable  <= '0;
         r_trigger <= '0;
      end else begin
         if (w_wr && (bus.addr_i == ADDR_ENABLE)) begin
            r_enable <= bus.wdata_i[NUM_SRC-1:0];
         end else begin
            r_enable <= r_enable;
         end
         if (w_wr && (bus.addr_i == ADDR_TRIGGER)) begin
            r_trigger <= bus.wdata_i[NUM_SRC-1:0];
         end else begin
            r_trigger <= r_trigger;
         end
      end
   end

   // Registered read data, held until the next read.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rdata <= 32'd0;
      end else if (w_rd) begin
         r_rdata <= w_rd_data;
      end else begin
         r_rdata <= r_rdata;
      end
   end

   // Interrupt delivery FSM with registered meip output.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state  <= ST_IDLE;
         r_cur_id <= 5'd0;
         r_meip   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_eligible) begin
                  r_state  <= ST_ASSERT;
                  r_cur_id <= w_win_id;
                  r_meip   <= 1'b1;
               end else begin
                  r_state  <= ST_IDLE;
                  r_cur_id <= 5'd0;
                  r_meip   <= 1'b0;
               end
            end
            ST_ASSERT: begin
               // cur_id stays frozen here: a higher-priority arrival does not
               // preempt the request already being signalled.
               if (w_claim) begin
                  r_state <= ST_SERVICE;
                  r_meip  <= 1'b0;
               end else if (!w_cur_eligible) begin
                  r_state  <= ST_IDLE;
                  r_cur_id <= 5'd0;
                  r_meip   <= 1'b0;
               end else begin
                  r_state <= ST_ASSERT;
                  r_meip  <= 1'b1;
               end
            end
            ST_SERVICE: begin
               r_meip <= 1'b0;
               if (w_complete) begin
                  r_state  <= ST_IDLE;
                  r_cur_id <= 5'd0;
               end else begin
                  r_state <= ST_SERVICE;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_cur_id <= 5'd0;
               r_meip   <= 1'b0;
            end
         endcase
      end
   end

endmodule
